// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, midpoint sampling, one-cycle valid or
// framing-error strobe per frame.
module uart_rx #(
    parameter int BAUD_RATE = 9600,
    parameter int CLOCK_HZ  = 12_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pin,
    // `byte` is a reserved word in SystemVerilog, so the received byte is `data`
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_error,
    output logic       busy
);
    localparam int CYCLES_PER_BIT = CLOCK_HZ / BAUD_RATE;
    localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int CW             = $clog2(CYCLES_PER_BIT) + 1;

    typedef enum logic [2:0] {RECOVER, IDLE, START, RECEIVE, STOP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [2:0]      index_q, index_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic [1:0]      sync_q;
    logic            s;

    assign s = sync_q[1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q  <= 2'b11;
            state_q <= RECOVER;
            count_q <= '0;
            index_q <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], pin};
            state_q <= state_d;
            count_q <= count_d;
            index_q <= index_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        index_d = index_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RECOVER: begin
                count_d = '0;
                index_d = '0;
                if (s) state_d = IDLE;
            end
            IDLE: begin
                count_d = '0;
                index_d = '0;
                if (!s) state_d = START;
            end
            START: begin
                // a start bit must still be low at its midpoint, else it was a glitch
                if (count_q == CW'(HALF_BIT - 1)) begin
                    count_d = '0;
                    state_d = s ? IDLE : RECEIVE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            RECEIVE: begin
                if (count_q == CW'(CYCLES_PER_BIT - 1)) begin
                    count_d          = '0;
                    shreg_d[index_q] = s;
                    if (index_q == 3'd7) begin
                        index_d = '0;
                        state_d = STOP;
                    end else begin
                        index_d = index_q + 1'b1;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            STOP: begin
                // leaves at mid stop bit, so a following start edge is never missed
                if (count_q == CW'(CYCLES_PER_BIT - 1)) begin
                    count_d = '0;
                    if (s) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = RECOVER;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            default: state_d = RECOVER;
        endcase
    end

    assign data        = data_q;
    assign valid       = valid_q;
    assign frame_error = ferr_q;
    assign busy        = (state_q != IDLE) && (state_q != RECOVER);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 12 clocks per bit; edge offsets are counted
// from the first clock edge that samples the start bit low.
module tb_uart_rx;
    localparam int CPB = 12;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       pin   = 1'b1;
    logic [7:0] data;
    logic       valid, frame_error, busy;

    int checks = 0;
    int errors = 0;

    uart_rx #(.BAUD_RATE(1_000_000), .CLOCK_HZ(12_000_000)) dut (
        .clock(clock), .reset(reset), .pin(pin),
        .data(data), .valid(valid), .frame_error(frame_error), .busy(busy)
    );

    always #50 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Event recorder, sampled on the falling edge
    int         valid_cnt = 0, fe_cnt = 0, both_cnt = 0;
    int         valid_cyc = 0, fe_cyc = 0, busy_rise = 0, busy_fall = 0;
    logic       busy_prev = 1'b0;
    logic [7:0] last_byte = 8'h00;
    logic [7:0] got[$];

    always @(negedge clock) begin
        if (valid) begin
            valid_cnt <= valid_cnt + 1;
            valid_cyc <= cyc;
            last_byte <= data;
            got.push_back(data);
        end
        if (frame_error) begin
            fe_cnt <= fe_cnt + 1;
            fe_cyc <= cyc;
        end
        if (valid && frame_error) both_cnt <= both_cnt + 1;
        if (busy && !busy_prev) busy_rise <= cyc;
        if (!busy && busy_prev) busy_fall <= cyc;
        busy_prev <= busy;
    end

    // Caller is 1 time unit after a rising edge; the next edge is edge 0
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int cpb);
        pin = 1'b0;
        repeat (cpb) @(posedge clock);
        #1;
        for (int k = 0; k < 8; k++) begin
            pin = d[k];
            repeat (cpb) @(posedge clock);
            #1;
        end
        pin = stop_bit;
        repeat (cpb) @(posedge clock);
        #1;
    endtask

    task automatic send_frame_ns(input logic [7:0] d, input int bit_ns);
        pin = 1'b0;
        #(bit_ns);
        for (int k = 0; k < 8; k++) begin
            pin = d[k];
            #(bit_ns);
        end
        pin = 1'b1;
        #(bit_ns);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
        checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", frame_error); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        reset = 1'b0;
        repeat (5) @(posedge clock);
    endtask

    task automatic test_single();
        int vc, fc, e0;
        vc = valid_cnt; fc = fe_cnt;
        @(posedge clock); #1;
        e0 = cyc + 1;
        send_frame(8'hA5, 1'b1, CPB);
        repeat (20) @(posedge clock);
        checks++; if (valid_cnt - vc !== 1) begin errors++; $display("FAIL single_valid_count got %0d want 1", valid_cnt - vc); end
        checks++; if (last_byte !== 8'hA5) begin errors++; $display("FAIL single_byte got %h want a5", last_byte); end
        checks++; if (valid_cyc - e0 !== 116) begin errors++; $display("FAIL single_valid_edge got %0d want 116", valid_cyc - e0); end
        checks++; if (fe_cnt !== fc) begin errors++; $display("FAIL single_ferr got %0d want %0d", fe_cnt, fc); end
        checks++; if (busy_rise - e0 !== 2) begin errors++; $display("FAIL single_busy_rise got %0d want 2", busy_rise - e0); end
        checks++; if (busy_fall - e0 !== 116) begin errors++; $display("FAIL single_busy_fall got %0d want 116", busy_fall - e0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b[3];
        logic [7:0] g;
        int fc;
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h55;
        fc = fe_cnt;
        got.delete();
        @(posedge clock); #1;
        for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1, CPB);
        repeat (20) @(posedge clock);
        checks++; if (got.size() !== 3) begin errors++; $display("FAIL b2b_count got %0d want 3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            g = (got.size() > i) ? got[i] : 8'hxx;
            checks++; if (g !== exp_b[i]) begin errors++; $display("FAIL b2b_byte%0d got %h want %h", i, g, exp_b[i]); end
        end
        checks++; if (fe_cnt !== fc) begin errors++; $display("FAIL b2b_ferr got %0d want %0d", fe_cnt, fc); end
    endtask

    task automatic test_glitch();
        int vc, fc, e0;
        vc = valid_cnt; fc = fe_cnt;
        @(posedge clock); #1;
        e0 = cyc + 1;
        pin = 1'b0;
        repeat (3) @(posedge clock);
        #1 pin = 1'b1;
        repeat (20) @(posedge clock);
        checks++; if (busy_fall - e0 !== 8) begin errors++; $display("FAIL glitch_idle_edge got %0d want 8", busy_fall - e0); end
        checks++; if (valid_cnt !== vc) begin errors++; $display("FAIL glitch_valid got %0d want %0d", valid_cnt, vc); end
        checks++; if (fe_cnt !== fc) begin errors++; $display("FAIL glitch_ferr got %0d want %0d", fe_cnt, fc); end
        @(posedge clock); #1;
        send_frame(8'h3C, 1'b1, CPB);
        repeat (20) @(posedge clock);
        checks++; if (valid_cnt - vc !== 1) begin errors++; $display("FAIL glitch_next_count got %0d want 1", valid_cnt - vc); end
        checks++; if (last_byte !== 8'h3C) begin errors++; $display("FAIL glitch_next_byte got %h want 3c", last_byte); end
    endtask

    task automatic test_framing();
        int vc, fc, e0;
        vc = valid_cnt; fc = fe_cnt;
        @(posedge clock); #1;
        e0 = cyc + 1;
        send_frame(8'h81, 1'b0, CPB);
        repeat (40) @(posedge clock);
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_low got %b want 0", busy); end
        @(posedge clock); #1 pin = 1'b1;
        repeat (20) @(posedge clock);
        checks++; if (fe_cnt - fc !== 1) begin errors++; $display("FAIL ferr_count got %0d want 1", fe_cnt - fc); end
        checks++; if (fe_cyc - e0 !== 116) begin errors++; $display("FAIL ferr_edge got %0d want 116", fe_cyc - e0); end
        checks++; if (valid_cnt !== vc) begin errors++; $display("FAIL ferr_valid got %0d want %0d", valid_cnt, vc); end
        checks++; if (data !== 8'h3C) begin errors++; $display("FAIL ferr_byte_kept got %h want 3c", data); end
        checks++; if (busy_rise - e0 !== 2) begin errors++; $display("FAIL ferr_no_restart last busy rise at %0d want 2", busy_rise - e0); end
    endtask

    task automatic test_reset_mid();
        int vc, fc;
        vc = valid_cnt; fc = fe_cnt;
        @(posedge clock); #1;
        fork
            send_frame(8'h96, 1'b1, CPB);
            begin
                repeat (67) @(posedge clock);
                #2 reset = 1'b1;
                #1;
                checks++; if (data !== 8'h00) begin errors++; $display("FAIL midrst_data got %h want 00", data); end
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
                checks++; if ({valid, frame_error} !== 2'b00) begin errors++; $display("FAIL midrst_strobes got %b want 00", {valid, frame_error}); end
                repeat (36) @(posedge clock);
                #2 reset = 1'b0;
            end
        join
        repeat (30) @(posedge clock);
        checks++; if (valid_cnt !== vc) begin errors++; $display("FAIL midrst_tail_valid got %0d want %0d", valid_cnt, vc); end
        checks++; if (fe_cnt !== fc) begin errors++; $display("FAIL midrst_tail_ferr got %0d want %0d", fe_cnt, fc); end
        @(posedge clock); #1;
        send_frame(8'h42, 1'b1, CPB);
        repeat (20) @(posedge clock);
        checks++; if (valid_cnt - vc !== 1) begin errors++; $display("FAIL midrst_next_count got %0d want 1", valid_cnt - vc); end
        checks++; if (last_byte !== 8'h42) begin errors++; $display("FAIL midrst_next_byte got %h want 42", last_byte); end
    endtask

    // Nominal bit is 1200 time units; 1164 and 1236 are -3% and +3%
    task automatic test_tolerance();
        int periods[2];
        int vc, fc;
        periods[0] = 1164; periods[1] = 1236;
        for (int i = 0; i < 2; i++) begin
            vc = valid_cnt; fc = fe_cnt;
            @(posedge clock); #1;
            send_frame_ns(8'hC3, periods[i]);
            repeat (20) @(posedge clock);
            checks++; if (valid_cnt - vc !== 1) begin errors++; $display("FAIL baud_%0d_count got %0d want 1", periods[i], valid_cnt - vc); end
            checks++; if (last_byte !== 8'hC3) begin errors++; $display("FAIL baud_%0d_byte got %h want c3", periods[i], last_byte); end
            checks++; if (fe_cnt !== fc) begin errors++; $display("FAIL baud_%0d_ferr got %0d want %0d", periods[i], fe_cnt, fc); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_reset_mid();
        test_tolerance();
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL exclusive_strobes got %0d overlaps want 0", both_cnt); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
